// File: rtl/latch_dump_serializer.sv
// rtl/latch_dump_serializer.sv - byte-wise dump of a captured snapshot to uart_tx, LSB byte first
// Optional READY_CHAR trailer; o_done pulses after the last byte's stop bit.
module latch_dump_serializer #(
  parameter int         MAX_BYTES  = 128,
  parameter int         CNT_WIDTH  = $clog2(MAX_BYTES + 1),
  parameter logic [7:0] READY_CHAR = 8'h52
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [MAX_BYTES*8-1:0] i_data,
  input  logic [CNT_WIDTH-1:0]   i_num_bytes,
  input  logic                   i_append_ready,
  input  logic                   i_tx_done,
  output logic                   o_tx_start,
  output logic [7:0]             o_tx_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [CNT_WIDTH-1:0]   o_byte_count
);

  localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT, S_TRAIL, S_TWAIT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           shadow [MAX_BYTES];
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_inc;
  logic [CNT_WIDTH-1:0] len_clamped;
  logic                 append_q;
  logic                 last_byte;

  assign count_inc   = count_q + CNT_WIDTH'(1);
  assign last_byte   = (count_inc == len_q);
  assign len_clamped = (i_num_bytes > CNT_WIDTH'(MAX_BYTES)) ? CNT_WIDTH'(MAX_BYTES) : i_num_bytes;
  assign o_byte_count = count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      count_q  <= '0;
      append_q <= 1'b0;
      for (int k = 0; k < MAX_BYTES; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && i_start) begin
        for (int k = 0; k < MAX_BYTES; k++) begin
          shadow[k] <= i_data[8*k +: 8];
        end
        len_q    <= len_clamped;
        append_q <= i_append_ready;
        count_q  <= '0;
      end else if (state_q == S_WAIT && i_tx_done) begin
        count_q <= count_inc;
      end
    end
  end

  // Outputs decode from the current state only, so tx_data stays put for the whole byte.
  always_comb begin
    state_d    = state_q;
    o_tx_start = 1'b0;
    o_tx_data  = '0;
    o_done     = 1'b0;
    o_busy     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (len_q == '0) state_d = append_q ? S_TRAIL : S_DONE;
        else             state_d = S_SEND;
      end
      S_SEND: begin
        o_tx_start = 1'b1;
        o_tx_data  = shadow[count_q[IDX_W-1:0]];
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        o_tx_data = shadow[count_q[IDX_W-1:0]];
        if (i_tx_done) begin
          if (last_byte) state_d = append_q ? S_TRAIL : S_DONE;
          else           state_d = S_SEND;
        end
      end
      S_TRAIL: begin
        o_tx_start = 1'b1;
        o_tx_data  = READY_CHAR;
        state_d    = S_TWAIT;
      end
      S_TWAIT: begin
        o_tx_data = READY_CHAR;
        if (i_tx_done) state_d = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_latch_dump_serializer.sv
// tb/tb_latch_dump_serializer.sv - directed bench with a transfer-level model and a uart_tx responder
// The model predicts byte order, pulse timing and counters from the transfer rules.
module tb_latch_dump_serializer;

  localparam int MAXB = 128;
  localparam int CW   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [MAXB*8-1:0] data = '0;
  logic [CW-1:0]     num = '0;
  logic              app = 1'b0;
  logic              tx_done = 1'b0;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              busy;
  logic              done;
  logic [CW-1:0]     byte_count;

  always #5 clk = ~clk;

  latch_dump_serializer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_data         (data),
    .i_num_bytes    (num),
    .i_append_ready (app),
    .i_tx_done      (tx_done),
    .o_tx_start     (tx_start),
    .o_tx_data      (tx_data),
    .o_busy         (busy),
    .o_done         (done),
    .o_byte_count   (byte_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Transfer-level model state, owned by the monitor process.
  int         cyc = 0;
  logic       m_busy = 1'b0;
  int         m_count = 0;
  logic [7:0] q[$];
  int         pay_left = 0;
  int         exp_start_cyc = -1;
  int         exp_done_cyc = -1;
  int         fire_cyc = -1;
  logic       in_flight = 1'b0;
  logic       cur_payload = 1'b0;
  logic [7:0] cur_byte = '0;
  logic [7:0] sent[$];
  int         accepted = 0;
  int         accept_cyc = 0;
  int         last_fire_cyc = 0;
  int         last_done_cyc = 0;
  logic       stray_used = 1'b0;

  // Driven only by the stimulus process.
  int         resp_delay = 3;
  logic       stray_arm = 1'b0;

  always @(negedge clk) begin
    int n;
    cyc++;
    tx_done = 1'b0;
    chk("busy", busy, m_busy);
    chk("byte_count", byte_count, m_count);
    chk("tx_start", tx_start, cyc == exp_start_cyc);
    chk("done", done, cyc == exp_done_cyc);
    if (done) last_done_cyc = cyc;
    if (cyc == exp_start_cyc) begin
      chk("byte_expected", q.size() > 0, 1'b1);
      if (q.size() > 0) begin
        chk("tx_data", tx_data, q[0]);
        cur_byte = q.pop_front();
        sent.push_back(tx_data);
        cur_payload = (pay_left > 0);
        if (cur_payload) pay_left--;
        in_flight = 1'b1;
        fire_cyc = cyc + resp_delay;
        if (stray_arm && !stray_used) begin
          tx_done = 1'b1;
          stray_used = 1'b1;
        end
      end
    end else if (in_flight) begin
      chk("tx_data_hold", tx_data, cur_byte);
    end
    if (in_flight && cyc == fire_cyc) begin
      tx_done = 1'b1;
      in_flight = 1'b0;
      last_fire_cyc = cyc;
      if (cur_payload) m_count++;
      if (q.size() > 0) exp_start_cyc = cyc + 1;
      else              exp_done_cyc  = cyc + 1;
    end
    if (rst) begin
      m_busy = 1'b0;
      m_count = 0;
      q.delete();
      pay_left = 0;
      in_flight = 1'b0;
      exp_start_cyc = -1;
      exp_done_cyc = -1;
    end else if (start && !m_busy) begin
      n = (num > MAXB) ? MAXB : int'(num);
      q.delete();
      sent.delete();
      for (int k = 0; k < n; k++) q.push_back(data[8*k +: 8]);
      if (app) q.push_back(8'h52);
      pay_left = n;
      m_busy = 1'b1;
      m_count = 0;
      accepted++;
      accept_cyc = cyc;
      if (q.size() > 0) exp_start_cyc = cyc + 2;
      else              exp_done_cyc  = cyc + 2;
    end else if (cyc == exp_done_cyc) begin
      m_busy = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [MAXB*8-1:0] d, input int n, input logic a);
    data  = d;
    num   = CW'(n);
    app   = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, seen, 1'b1);
    tick();
  endtask

  logic [MAXB*8-1:0] d;
  logic [7:0] e1 [4]  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] e4 [8]  = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
  int acc_before;

  initial begin
    repeat (3) tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_tx_start", tx_start, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_count", byte_count, 0);
    chk("reset_tx_data", tx_data, 0);
    rst = 1'b0;
    tick();

    // 1: four bytes, slow responder
    resp_delay = 10;
    d = '0;
    d[31:0] = 32'hDEADBEEF;
    launch(d, 4, 1'b0);
    wait_done("t1_done_seen", 200);
    chk("t1_len", sent.size(), 4);
    if (sent.size() == 4) for (int k = 0; k < 4; k++) chk("t1_byte", sent[k], e1[k]);
    chk("t1_count", byte_count, 4);
    chk("t1_done_after_txdone", last_done_cyc - last_fire_cyc, 1);
    resp_delay = 3;

    // 2: 17 bytes plus trailer
    d = '0;
    for (int k = 0; k < MAXB; k++) d[8*k +: 8] = 8'(k);
    launch(d, 17, 1'b1);
    wait_done("t2_done_seen", 400);
    chk("t2_len", sent.size(), 18);
    if (sent.size() == 18) begin
      chk("t2_last_payload", sent[16], 8'h10);
      chk("t2_trailer", sent[17], 8'h52);
    end
    chk("t2_count", byte_count, 17);

    // 3: empty payloads
    launch(d, 0, 1'b1);
    wait_done("t3a_done_seen", 50);
    chk("t3a_len", sent.size(), 1);
    if (sent.size() == 1) chk("t3a_trailer", sent[0], 8'h52);
    chk("t3a_count", byte_count, 0);
    launch(d, 0, 1'b0);
    wait_done("t3b_done_seen", 50);
    chk("t3b_len", sent.size(), 0);
    chk("t3b_done_latency", last_done_cyc - accept_cyc, 2);

    // 4: restart attempt, data change and stray tx_done mid-transfer
    d = '0;
    d[63:0] = 64'h0123456789ABCDEF;
    acc_before = accepted;
    stray_arm = 1'b1;
    launch(d, 8, 1'b0);
    repeat (12) tick();
    data = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4_done_seen", 300);
    chk("t4_len", sent.size(), 8);
    if (sent.size() == 8) for (int k = 0; k < 8; k++) chk("t4_byte", sent[k], e4[k]);
    chk("t4_count", byte_count, 8);
    repeat (5) tick();
    chk("t4_single_transfer", accepted - acc_before, 1);
    chk("t4_idle_after", busy, 1'b0);

    // 5: full register dump, then clamped length
    d = '0;
    for (int k = 0; k < MAXB; k++) d[8*k +: 8] = 8'(k) ^ 8'hA5;
    launch(d, 128, 1'b1);
    wait_done("t5a_done_seen", 2000);
    chk("t5a_len", sent.size(), 129);
    if (sent.size() == 129) begin
      chk("t5a_byte127", sent[127], 8'hDA);
      chk("t5a_trailer", sent[128], 8'h52);
    end
    chk("t5a_count", byte_count, 128);
    launch(d, 200, 1'b0);
    wait_done("t5b_done_seen", 2000);
    chk("t5b_len", sent.size(), 128);
    chk("t5b_count", byte_count, 128);

    // 6: reset after the third byte of nine
    d = '0;
    for (int k = 0; k < MAXB; k++) d[8*k +: 8] = 8'(8'h30 + k);
    launch(d, 9, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if (m_count >= 3) break;
      tick();
    end
    chk("t6_reached_third", m_count >= 3, 1'b1);
    rst = 1'b1;
    tick();
    chk("t6_busy", busy, 1'b0);
    chk("t6_tx_start", tx_start, 1'b0);
    chk("t6_count", byte_count, 0);
    rst = 1'b0;
    repeat (3) tick();
    launch(d, 9, 1'b0);
    wait_done("t6_done_seen", 400);
    chk("t6_len", sent.size(), 9);
    if (sent.size() == 9) chk("t6_first_byte", sent[0], 8'h30);
    chk("t6_final_count", byte_count, 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/latch_dump_serializer.md
Name: latch_dump_serializer

Overview:
- Downstream of the debug unit's snapshot mux and upstream of `uart_tx`.
- Captures a wide snapshot (IF/ID, ID/EX, EX/MEM or MEM/WB latch, or the register file) and sends it to the host one byte at a time, LSB byte first.
- Optionally appends the ASCII ready marker 'R' (0x52) after the payload.
- Pulses done when the whole transfer has left the transmitter.

Parameters:
- MAX_BYTES, 128, maximum payload bytes per transfer (register file = 32 x 4).
- CNT_WIDTH, $clog2(MAX_BYTES+1), width of byte counters.
- READY_CHAR, 8'h52, trailer byte sent when i_append_ready is set.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous active-high reset.
- i_start  input  1  request a transfer; sampled only in IDLE.
- i_data  input  MAX_BYTES*8  snapshot; byte k = i_data[8k+7:8k].
- i_num_bytes  input  CNT_WIDTH  payload length, 0..MAX_BYTES.
- i_append_ready  input  1  send READY_CHAR after the payload.
- i_tx_done  input  1  one-cycle pulse from `uart_tx` at the end of the stop bit.
- o_tx_start  output  1  one-cycle pulse launching a byte.
- o_tx_data  output  8  byte to transmit; stable from the start pulse until the matching i_tx_done.
- o_busy  output  1  transfer in progress.
- o_done  output  1  one-cycle completion pulse.
- o_byte_count  output  CNT_WIDTH  payload bytes fully sent so far in the current transfer.

Behaviour:
- Clock and reset: single clock i_clk. Reset is synchronous, active-high, on i_rst.
- Reset values:
  - o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, o_byte_count=0.
  - State=IDLE, shadow register cleared.
- States: IDLE, LOAD, SEND, WAIT, TRAIL, TWAIT, DONE.
- IDLE:
  - On the edge where i_start=1, copy i_data to the shadow register, latch length and trailer flag, clear o_byte_count, go to LOAD.
  - i_num_bytes > MAX_BYTES is clamped to MAX_BYTES.
- LOAD:
  - o_busy=1.
  - If length=0, go to TRAIL when the trailer flag is set, else go to DONE.
  - Otherwise go to SEND.
- SEND:
  - o_tx_start=1 for exactly this cycle.
  - o_tx_data = shadow byte indexed by o_byte_count.
  - Next state is WAIT.
  - First start pulse occurs 2 cycles after the i_start sample edge.
- WAIT:
  - Hold o_tx_data.
  - On i_tx_done, increment o_byte_count. If count+1 equals length, go to TRAIL (trailer flag set) or DONE; else go to SEND.
  - Gap between i_tx_done and the next start pulse is exactly 1 cycle.
- TRAIL: o_tx_start=1 for one cycle with o_tx_data=READY_CHAR, then go to TWAIT.
- TWAIT: on i_tx_done go to DONE. o_byte_count does not count the trailer.
- DONE:
  - o_done=1 and o_busy=1 for one cycle, then return to IDLE.
  - o_byte_count holds its final value until the next accepted i_start.
- Ignored inputs:
  - i_start outside IDLE is ignored; no queuing.
  - i_tx_done outside WAIT/TWAIT is ignored.
  - Changes to i_data after capture have no effect on the transfer in flight.
  - i_tx_done coinciding with the start pulse in SEND is ignored; the block still waits in WAIT for a fresh pulse.
- Reset mid-transfer: the next edge forces IDLE with all outputs at reset values; the partial byte in `uart_tx` is not tracked.
- Invariant: o_tx_start is never asserted while in WAIT/TWAIT (at most one byte in flight).

Test Plan:
1. Reset, then i_start with i_num_bytes=4, i_data[31:0]=32'hDEADBEEF, append=0, i_tx_done pulsed 10 cycles after each start pulse -> bytes EF, BE, AD, DE in order; o_done 1 cycle after the 4th i_tx_done; o_byte_count=4; no 0x52.
2. Length 17, append=1, i_data byte k = k -> bytes 00..10 followed by 52; o_byte_count=17; exactly 18 start pulses.
3. Length 0, append=1 -> single byte 52; o_byte_count=0; o_done asserted. Length 0, append=0 -> no start pulse; o_done 2 cycles after i_start.
4. i_start re-pulsed and i_data changed mid-transfer of 8 bytes; stray i_tx_done while in SEND -> original 8 bytes sent unchanged; no extra transfer; byte count unaffected by the stray pulse.
5. Length 128 (register dump), append=1 -> 129 bytes; byte 127 = i_data[1023:1016]. Length 200 -> clamped; 128 payload bytes sent.
6. i_rst asserted after the 3rd byte of 9 -> next cycle o_busy=0, o_tx_start=0, o_byte_count=0. Subsequent i_start restarts from byte 0.
